// File: rtl/button_repeat_if.sv
// ---------------------------------------------------------------------------
// button_repeat_if
//   Event handshake between the button auto-repeat block and the FIFO
//   front end that consumes its press / repeat commands.
//
//   event_valid   producer -> consumer  an event is pending
//   event_repeat  producer -> consumer  0 = initial press, 1 = auto-repeat
//   event_ready   consumer -> producer  event taken when valid && ready
//
//   master : the event producer (button_repeat)
//   slave  : the event consumer
// ---------------------------------------------------------------------------
interface button_repeat_if;
  logic event_valid;
  logic event_repeat;
  logic event_ready;

  modport master (
    output event_valid,
    output event_repeat,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_repeat,
    output event_ready
  );
endinterface

// File: rtl/button_repeat.sv
// ---------------------------------------------------------------------------
// button_repeat
//   Turns a debounced button level into discrete command events: one event
//   when the button is pressed, then auto-repeat events for as long as it
//   stays held. Events sit in a one-entry output register offered on a
//   valid/ready handshake; an event that cannot be stored is dropped and
//   recorded in a sticky overrun flag.
//
//   Ports
//     clk            system clock (5 kHz), rising edge
//     reset          synchronous, active-high reset
//     level          debounced button level, 1 = pressed
//     evt            event handshake (master side): valid / repeat / ready
//     overrun        sticky: an event was dropped
//     clear_overrun  clears overrun at the next edge (a drop on the same
//                    edge wins)
//
//   Parameters
//     HOLD_CYCLES    edges from the press event to the first repeat
//     REPEAT_CYCLES  edges between consecutive repeat events
//     CNT_W          interval counter width
// ---------------------------------------------------------------------------
module button_repeat #(
  parameter int unsigned HOLD_CYCLES   = 2500,
  parameter int unsigned REPEAT_CYCLES = 500,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                level,
  button_repeat_if.master     evt,
  output logic                overrun,
  input  logic                clear_overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] next_counter;
  logic             armed;
  logic             gen_event;
  logic             gen_repeat;
  logic             valid_q;
  logic             repeat_q;
  logic             accept;

  assign evt.event_valid  = valid_q;
  assign evt.event_repeat = repeat_q;
  assign accept           = valid_q && evt.event_ready;

  // State register and interval counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
    end
  end

  // armed only ever gets set by seeing the button released, so a button
  // held through reset cannot fire until it has been let go once.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (!level) begin
      armed <= 1'b1;
    end
  end

  // Next-state logic and event generation. The counter is cleared on every
  // state change and the compare caps it, so it cannot wrap.
  always_comb begin
    next_state   = state;
    next_counter = '0;
    gen_event    = 1'b0;
    gen_repeat   = 1'b0;
    unique case (state)
      IDLE: begin
        if (level && armed) begin
          gen_event  = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (!level) begin
          next_state = IDLE;
        end else if (counter == HOLD_LAST) begin
          gen_event  = 1'b1;
          gen_repeat = 1'b1;
          next_state = REPEAT;
        end else begin
          next_counter = counter + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!level) begin
          next_state = IDLE;
        end else if (counter == REPEAT_LAST) begin
          gen_event  = 1'b1;
          gen_repeat = 1'b1;
        end else begin
          next_counter = counter + CNT_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // One-entry event register. A new event may be loaded into a slot that is
  // empty or being emptied on this same edge; otherwise it is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      repeat_q <= 1'b0;
    end else if (gen_event && (!valid_q || accept)) begin
      valid_q  <= 1'b1;
      repeat_q <= gen_repeat;
    end else if (accept) begin
      valid_q  <= 1'b0;
    end
  end

  // Sticky overrun; a drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (gen_event && valid_q && !evt.event_ready) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_repeat.sv
// ---------------------------------------------------------------------------
// tb_button_repeat
//   Bench for button_repeat with HOLD_CYCLES=4, REPEAT_CYCLES=3. A reference
//   model expresses event timing as arithmetic on how many edges the button
//   has been held since an armed press, and keeps the one-deep output slot
//   and the overrun flag as plain variables.
// ---------------------------------------------------------------------------
module tb_button_repeat;

  localparam int HOLD = 4;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic reset;
  logic level;
  logic overrun;
  logic clear_overrun;

  button_repeat_if bus ();

  button_repeat #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .CNT_W         (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .level         (level),
    .evt           (bus.master),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int checks      = 0;
  int miscompares = 0;

  // Reference model state: held = edges since the armed press (-1 = not in
  // a press), plus the output slot contents and the overrun flag.
  int   m_held  = -1;
  logic m_armed = 1'b0;
  logic m_valid = 1'b0;
  logic m_rep   = 1'b0;
  logic m_ovr   = 1'b0;

  // Advance the reference model by one clock edge using the driven inputs.
  task automatic modelEdge(input logic l, input logic r, input logic c,
                           input logic rs);
    logic gen;
    logic gen_rep;
    logic acc;
    if (rs) begin
      m_held  = -1;
      m_armed = 1'b0;
      m_valid = 1'b0;
      m_rep   = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (!l)              m_held = -1;
      else if (m_held >= 0) m_held = m_held + 1;
      else if (m_armed)    m_held = 0;
      if (!l) m_armed = 1'b1;
      gen     = (m_held == 0) ||
                (m_held >= HOLD && ((m_held - HOLD) % REP) == 0);
      gen_rep = (m_held > 0);
      acc     = m_valid && r;
      if (gen && m_valid && !r) m_ovr = 1'b1;
      else if (c)               m_ovr = 1'b0;
      if (gen && (!m_valid || acc)) begin
        m_valid = 1'b1;
        m_rep   = gen_rep;
      end else if (acc) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic checkBit(input string tag, input logic observed,
                          input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b at vector %0d",
             tag, observed, expected, vectors);
    end
  endtask

  task automatic checkOutput();
    checkBit("event_valid", bus.event_valid, m_valid);
    checkBit("event_repeat", bus.event_repeat, m_rep);
    checkBit("overrun", overrun, m_ovr);
  endtask

  // Drive one cycle of inputs, clock it, update the model, then compare
  // one time unit after the edge.
  task automatic applyStimulus(input logic l, input logic r, input logic c,
                               input logic rs);
    level         = l;
    bus.event_ready = r;
    clear_overrun = c;
    reset         = rs;
    @(posedge clk);
    modelEdge(l, r, c, rs);
    #1;
    vectors++;
    checkOutput();
  endtask

  initial begin
    level           = 1'b0;
    bus.event_ready = 1'b1;
    clear_overrun   = 1'b0;
    reset           = 1'b1;
    #2;

    // Reset state.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkBit("reset_valid", bus.event_valid, 1'b0);
    checkBit("reset_overrun", overrun, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Single short press: one press event, valid for one cycle.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkBit("short_press_valid", bus.event_valid, 1'b1);
    checkBit("short_press_type", bus.event_repeat, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkBit("short_press_gone", bus.event_valid, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Long hold: events at k, k+4, k+7, k+10.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 4 || i == 7 || i == 10) begin
        checkBit("hold_repeat_valid", bus.event_valid, 1'b1);
        checkBit("hold_repeat_type", bus.event_repeat, 1'b1);
      end
      if (i == 5) checkBit("hold_gap", bus.event_valid, 1'b0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Backpressure: the k+4 repeat is dropped and overrun sets.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 3) checkBit("bp_no_overrun_yet", overrun, 1'b0);
      if (i == 4) checkBit("bp_overrun_set", overrun, 1'b1);
    end
    checkBit("bp_press_kept", bus.event_repeat, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkBit("bp_drained", bus.event_valid, 1'b0);
    checkBit("bp_cleared", overrun, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Accept and new event on the same edge (ready only at k+4).
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, (i == 4), 1'b0, 1'b0);
    checkBit("swap_valid", bus.event_valid, 1'b1);
    checkBit("swap_type", bus.event_repeat, 1'b1);
    checkBit("swap_no_overrun", overrun, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-hold: no event until released and pressed again.
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkBit("mid_reset_valid", bus.event_valid, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkBit("held_thru_reset", bus.event_valid, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkBit("repress_valid", bus.event_valid, 1'b1);
    checkBit("repress_type", bus.event_repeat, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Release exactly at the first repeat boundary: no repeat.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkBit("boundary_release", bus.event_valid, 1'b0);
    end

    // Randomised phase: sticky button level, random ready/clear/reset.
    begin
      logic l = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 9) == 0) l = ~l;
        applyStimulus(l, ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 15) == 0),
                      ($urandom_range(0, 149) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
